// File: rtl/seq_cu_pkg.sv
// Shared types, opcodes and instruction field offsets for the sequencing control unit.
// Field layout, MSB down: dst (RSW) | src (RSW) | op (3) | alu_sel (ALU_SEL_W) | mode (1) | ignored.
package seq_cu_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    T1    = 3'd2,
    T2    = 3'd3,
    T3    = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    CLS_MV  = 2'd0,
    CLS_MVI = 2'd1,
    CLS_ALU = 2'd2,
    CLS_ILL = 2'd3
  } op_class_t;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ALU = 3'b010;

  localparam int unsigned OP_W = 3;

  function automatic int unsigned dst_lsb(input int unsigned inst_w, input int unsigned rsw);
    return inst_w - rsw;
  endfunction

  function automatic int unsigned src_lsb(input int unsigned inst_w, input int unsigned rsw);
    return inst_w - 2 * rsw;
  endfunction

  function automatic int unsigned op_lsb(input int unsigned inst_w, input int unsigned rsw);
    return inst_w - 2 * rsw - OP_W;
  endfunction

  function automatic int unsigned alu_lsb(input int unsigned inst_w, input int unsigned rsw,
                                          input int unsigned alu_w);
    return op_lsb(inst_w, rsw) - alu_w;
  endfunction

  function automatic int unsigned mode_bit(input int unsigned inst_w, input int unsigned rsw,
                                           input int unsigned alu_w);
    return alu_lsb(inst_w, rsw, alu_w) - 1;
  endfunction

  // Bits actually occupied by the decoded fields.
  function automatic int unsigned fields_w(input int unsigned rsw, input int unsigned alu_w);
    return 2 * rsw + OP_W + alu_w + 1;
  endfunction

endpackage

// File: rtl/seq_cu_decoder.sv
// Combinational instruction decoder: splits reg_inst into fields, classifies the
// opcode and flags instructions that must be rejected.
// Ports: inst (raw instruction) -> op_class, dst, src, alu_sel, mode, illegal.
module seq_cu_decoder
  import seq_cu_pkg::*;
#(
  parameter int unsigned NUM_REGS  = 8,
  parameter int unsigned RSW       = 3,
  parameter int unsigned INST_W    = 16,
  parameter int unsigned ALU_SEL_W = 4
) (
  input  logic [INST_W-1:0]    inst,
  output op_class_t            op_class,
  output logic [RSW-1:0]       dst,
  output logic [RSW-1:0]       src,
  output logic [ALU_SEL_W-1:0] alu_sel,
  output logic                 mode,
  output logic                 illegal
);

  localparam int unsigned DST_LSB  = dst_lsb(INST_W, RSW);
  localparam int unsigned SRC_LSB  = src_lsb(INST_W, RSW);
  localparam int unsigned OP_LSB   = op_lsb(INST_W, RSW);
  localparam int unsigned ALU_LSB  = alu_lsb(INST_W, RSW, ALU_SEL_W);
  localparam int unsigned MODE_BIT = mode_bit(INST_W, RSW, ALU_SEL_W);
  localparam int unsigned RW       = RSW + 1;

  logic [OP_W-1:0] op;
  logic            dst_ok;
  logic            src_ok;

  assign dst     = inst[DST_LSB +: RSW];
  assign src     = inst[SRC_LSB +: RSW];
  assign op      = inst[OP_LSB +: OP_W];
  assign alu_sel = inst[ALU_LSB +: ALU_SEL_W];
  assign mode    = inst[MODE_BIT];

  // One extra bit so the compare stays meaningful when NUM_REGS == 2**RSW.
  assign dst_ok = {1'b0, dst} < RW'(NUM_REGS);
  assign src_ok = {1'b0, src} < RW'(NUM_REGS);

  // Opcode classification.
  always_comb begin
    op_class = CLS_ILL;
    case (op)
      OP_MV:   op_class = CLS_MV;
      OP_MVI:  op_class = CLS_MVI;
      OP_ALU:  op_class = CLS_ALU;
      default: op_class = CLS_ILL;
    endcase
  end

  // MVI has no source register, so its src field is not range checked.
  assign illegal = (op_class == CLS_ILL) || !dst_ok ||
                   (((op_class == CLS_MV) || (op_class == CLS_ALU)) && !src_ok);

  // Bits below the mode field carry no meaning.
  if (MODE_BIT > 0) begin : g_spare
    logic unused_spare;
    assign unused_spare = ^inst[MODE_BIT-1:0];
  end

endmodule

// File: rtl/seq_control_unit.sv
// Multi-cycle control FSM for the register-file datapath with run/done handshake.
// Ports: clk, rst_n, run, reg_inst in; en_i/en_s/en_c enables, mux_select, sel_din,
// sel_g, alu_select, alu_mode, one-hot reg_en, done/illegal pulses, busy and the
// retired-instruction counter inst_count out. Control outputs are decoded
// combinationally from state and reg_inst; only state and inst_count are flops.
module seq_control_unit
  import seq_cu_pkg::*;
#(
  parameter int unsigned NUM_REGS  = 8,
  parameter int unsigned RSW       = 3,
  parameter int unsigned INST_W    = 16,
  parameter int unsigned ALU_SEL_W = 4,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 run,
  input  logic [INST_W-1:0]    reg_inst,
  output logic                 en_i,
  output logic                 en_s,
  output logic                 en_c,
  output logic [RSW-1:0]       mux_select,
  output logic                 sel_din,
  output logic                 sel_g,
  output logic [ALU_SEL_W-1:0] alu_select,
  output logic                 alu_mode,
  output logic [NUM_REGS-1:0]  reg_en,
  output logic                 done,
  output logic                 illegal,
  output logic                 busy,
  output logic [CNT_W-1:0]     inst_count
);

  if ((NUM_REGS < 2) || (NUM_REGS > (1 << RSW))) begin : g_bad_num_regs
    $error("seq_control_unit: NUM_REGS must lie in 2..2**RSW");
  end
  // The decoded fields must fit inside the instruction word.
  if (fields_w(RSW, ALU_SEL_W) > INST_W) begin : g_bad_inst_w
    $error("seq_control_unit: instruction fields do not fit in INST_W");
  end

  state_t                state, next_state;
  op_class_t             op_class;
  logic [RSW-1:0]        dst, src;
  logic [ALU_SEL_W-1:0]  dec_alu_sel;
  logic                  dec_mode;
  logic                  dec_illegal;
  logic [NUM_REGS-1:0]   dst_onehot;

  seq_cu_decoder #(
    .NUM_REGS  (NUM_REGS),
    .RSW       (RSW),
    .INST_W    (INST_W),
    .ALU_SEL_W (ALU_SEL_W)
  ) u_decoder (
    .inst     (reg_inst),
    .op_class (op_class),
    .dst      (dst),
    .src      (src),
    .alu_sel  (dec_alu_sel),
    .mode     (dec_mode),
    .illegal  (dec_illegal)
  );

  // dst is range-checked before this is ever used as a write enable.
  assign dst_onehot = NUM_REGS'(1) << dst;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state and control decode.
  always_comb begin
    next_state = state;
    en_i       = 1'b0;
    en_s       = 1'b0;
    en_c       = 1'b0;
    mux_select = '0;
    sel_din    = 1'b0;
    sel_g      = 1'b0;
    alu_select = '0;
    alu_mode   = 1'b0;
    reg_en     = '0;
    done       = 1'b0;
    illegal    = 1'b0;

    case (state)
      IDLE: begin
        if (run) next_state = FETCH;
      end
      FETCH: begin
        en_i       = 1'b1;
        next_state = T1;
      end
      T1: begin
        if (dec_illegal) begin
          done    = 1'b1;
          illegal = 1'b1;
        end else begin
          case (op_class)
            CLS_MV: begin
              mux_select = src;
              reg_en     = dst_onehot;
              done       = 1'b1;
            end
            CLS_MVI: begin
              sel_din = 1'b1;
              reg_en  = dst_onehot;
              done    = 1'b1;
            end
            CLS_ALU: begin
              en_s       = 1'b1;
              mux_select = dst;
              next_state = T2;
            end
            default: begin
              done    = 1'b1;
              illegal = 1'b1;
            end
          endcase
        end
      end
      T2: begin
        en_c       = 1'b1;
        mux_select = src;
        alu_select = dec_alu_sel;
        alu_mode   = dec_mode;
        next_state = T3;
      end
      T3: begin
        sel_g  = 1'b1;
        reg_en = dst_onehot;
        done   = 1'b1;
      end
      default: next_state = IDLE;
    endcase

    // run is sampled at instruction end to chain straight into the next fetch.
    if (done) next_state = run ? FETCH : IDLE;
  end

  assign busy = (state != IDLE);

  // Retired legal instruction counter, wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                inst_count <= '0;
    else if (done && !illegal) inst_count <= inst_count + CNT_W'(1);
  end

endmodule

// File: tb/tb_seq_control_unit.sv
// Scoreboard bench: stimulus pushes hand-computed expectations, a negedge monitor
// pops one per fetch and checks the T1/T2/done controls, latency and counter.
module tb_seq_control_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, run;
  logic [15:0] reg_inst;
  logic        en_i, en_s, en_c, sel_din, sel_g, alu_mode, done, illegal, busy;
  logic [2:0]  mux_select;
  logic [3:0]  alu_select;
  logic [7:0]  reg_en;
  logic [3:0]  inst_count;

  logic        run_b;
  logic [15:0] reg_inst_b;
  logic        en_i_b, en_s_b, en_c_b, sel_din_b, sel_g_b, alu_mode_b, done_b, illegal_b, busy_b;
  logic [2:0]  mux_select_b;
  logic [3:0]  alu_select_b;
  logic [5:0]  reg_en_b;
  logic [15:0] inst_count_b;

  seq_control_unit #(.NUM_REGS(8), .RSW(3), .INST_W(16), .ALU_SEL_W(4), .CNT_W(4)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .run(run), .reg_inst(reg_inst),
    .en_i(en_i), .en_s(en_s), .en_c(en_c), .mux_select(mux_select),
    .sel_din(sel_din), .sel_g(sel_g), .alu_select(alu_select), .alu_mode(alu_mode),
    .reg_en(reg_en), .done(done), .illegal(illegal), .busy(busy), .inst_count(inst_count)
  );

  seq_control_unit #(.NUM_REGS(6), .RSW(3), .INST_W(16), .ALU_SEL_W(4), .CNT_W(16)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .run(run_b), .reg_inst(reg_inst_b),
    .en_i(en_i_b), .en_s(en_s_b), .en_c(en_c_b), .mux_select(mux_select_b),
    .sel_din(sel_din_b), .sel_g(sel_g_b), .alu_select(alu_select_b), .alu_mode(alu_mode_b),
    .reg_en(reg_en_b), .done(done_b), .illegal(illegal_b), .busy(busy_b),
    .inst_count(inst_count_b)
  );

  typedef struct {
    logic       is_alu;
    logic       ill;
    logic [2:0] smux;
    logic [2:0] cmux;
    logic [2:0] mux;
    logic [3:0] asel;
    logic       amode;
    logic       sdin;
    logic       sg;
    logic [7:0] regen;
    int         lat;
    logic [3:0] cnt;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] inst_q[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
    end
  endtask

  task automatic push(input logic [15:0] inst, input logic is_alu, input logic ill,
                      input logic [2:0] smux, input logic [2:0] cmux, input logic [2:0] mux,
                      input logic [3:0] asel, input logic amode, input logic sdin,
                      input logic sg, input logic [7:0] regen, input int lat,
                      input logic [3:0] cnt);
    exp_t e;
    e.is_alu = is_alu; e.ill = ill; e.smux = smux; e.cmux = cmux; e.mux = mux;
    e.asel = asel; e.amode = amode; e.sdin = sdin; e.sg = sg; e.regen = regen;
    e.lat = lat; e.cnt = cnt;
    exp_q.push_back(e);
    inst_q.push_back(inst);
  endtask

  // Hand-decoded vectors: MV R2<-R5, MVI R7, ALU R1=R1 op R3 (sel 9, mode 1), illegal op 111.
  task automatic push_mv(input logic [3:0] cnt);
    push(16'h5400, 1'b0, 1'b0, 3'd0, 3'd0, 3'd5, 4'h0, 1'b0, 1'b0, 1'b0, 8'h04, 2, cnt);
  endtask
  task automatic push_mvi(input logic [3:0] cnt);
    push(16'hE080, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 4'h0, 1'b0, 1'b1, 1'b0, 8'h80, 2, cnt);
  endtask
  task automatic push_alu(input logic [3:0] cnt);
    push(16'h2D4C, 1'b1, 1'b0, 3'd1, 3'd3, 3'd0, 4'h9, 1'b1, 1'b0, 1'b1, 8'h02, 4, cnt);
  endtask
  task automatic push_ill(input logic [3:0] cnt);
    push(16'h0380, 1'b0, 1'b1, 3'd0, 3'd0, 3'd0, 4'h0, 1'b0, 1'b0, 1'b0, 8'h00, 2, cnt);
  endtask

  // Instruction register model: loads during FETCH so the word is valid in T1.
  always @(negedge clk) begin
    if (rst_n && en_i) begin
      if (inst_q.size() > 0) reg_inst = inst_q.pop_front();
      else                   reg_inst = 16'h0380;
    end
  end

  // Monitor / scoreboard.
  exp_t       cur;
  logic       active = 1'b0;
  int         fetch_cyc = 0;
  logic       cnt_pend = 1'b0;
  logic [3:0] cnt_exp = '0;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      active   = 1'b0;
      cnt_pend = 1'b0;
    end else begin
      if (cnt_pend) begin
        chk("inst_count", 32'(inst_count), 32'(cnt_exp));
        cnt_pend = 1'b0;
      end
      chk("exclusive", 32'(($countones({en_s, en_c, sel_din, sel_g}) <= 1) && $onehot0(reg_en)), 1);
      if (en_i) begin
        if (exp_q.size() == 0) chk("unexpected_fetch", 1, 0);
        else begin
          cur       = exp_q.pop_front();
          active    = 1'b1;
          fetch_cyc = cyc;
        end
      end
      if (en_s) begin
        chk("t1_alu", 32'(active && cur.is_alu), 1);
        chk("t1_mux", 32'(mux_select), 32'(cur.smux));
      end
      if (en_c) chk("t2_ctl", 32'({mux_select, alu_select, alu_mode}),
                    32'({cur.cmux, cur.asel, cur.amode}));
      if (done) begin
        if (!active) chk("unexpected_done", 1, 0);
        else begin
          chk("done_ctl", 32'({mux_select, sel_din, sel_g, illegal, reg_en}),
              32'({cur.mux, cur.sdin, cur.sg, cur.ill, cur.regen}));
          chk("latency", cyc - fetch_cyc + 1, cur.lat);
          cnt_exp  = cur.cnt;
          cnt_pend = 1'b1;
          active   = 1'b0;
        end
      end
    end
  end

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_run();
    run = 1'b1;
    @(negedge clk);
    chk("fetch_after_run", 32'(en_i), 1);
    run = 1'b0;
  endtask

  task automatic wait_done(input int n);
    int seen = 0;
    for (int k = 0; k < 100 && seen < n; k++) begin
      @(negedge clk);
      if (done) seen++;
    end
    if (seen < n) chk("done_timeout", seen, n);
  endtask

  task automatic wait_en_c();
    logic got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      got = en_c;
    end
    if (!got) chk("en_c_timeout", 0, 1);
  endtask

  task automatic check_quiet(input string name);
    chk(name, 32'({en_i, en_s, en_c, mux_select, sel_din, sel_g, alu_select, alu_mode,
                   reg_en, done, illegal, busy, inst_count}), 0);
  endtask

  task automatic check_drained(input string name);
    chk(name, 32'({busy, active}), 0);
    chk({name, "_q"}, exp_q.size(), 0);
  endtask

  task automatic run_b_check(input logic [15:0] inst, input logic ill, input logic [5:0] regen,
                             input logic [15:0] cnt);
    logic found = 1'b0;
    reg_inst_b = inst;
    run_b      = 1'b1;
    @(negedge clk);
    run_b = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      if (done_b) begin
        found = 1'b1;
        chk("b_done", 32'({illegal_b, reg_en_b}), 32'({ill, regen}));
      end
    end
    if (!found) chk("b_done_timeout", 0, 1);
    @(negedge clk);
    chk("b_count", 32'(inst_count_b), 32'(cnt));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    run        = 1'b0;
    reg_inst   = 16'h0000;
    run_b      = 1'b0;
    reg_inst_b = 16'h0000;
    settle(2);
    check_quiet("reset_outs");
    rst_n = 1'b1;
    settle(2);
    check_quiet("idle_after_reset");

    // MV R2<-R5 with a one-cycle run pulse.
    push_mv(4'd1);
    pulse_run();
    settle(4);
    check_drained("mv_idle");

    // MVI R7 with run held, chaining straight into an MV.
    push_mvi(4'd2);
    push_mv(4'd3);
    run = 1'b1;
    wait_done(1);
    @(negedge clk);
    chk("b2b_fetch", 32'(en_i), 1);
    run = 1'b0;
    settle(5);
    check_drained("b2b_idle");

    // ALU R1 = R1 op R3.
    push_alu(4'd4);
    pulse_run();
    settle(6);
    check_drained("alu_idle");

    // Illegal opcode: count must not move.
    push_ill(4'd4);
    pulse_run();
    settle(4);
    check_drained("ill_idle");

    // Twelve more legal instructions wrap the 4-bit counter; run drops in the last ALU's T2.
    for (int i = 0; i < 11; i++) begin
      if (i % 2 == 0) push_mv(4'(5 + i));
      else            push_mvi(4'(5 + i));
    end
    push_alu(4'd0);
    run = 1'b1;
    wait_done(11);
    wait_en_c();
    run = 1'b0;
    settle(5);
    chk("wrap_count", 32'(inst_count), 0);
    check_drained("wrap_idle");

    // Reset asserted while an ALU op sits in T2.
    push_alu(4'd1);
    pulse_run();
    wait_en_c();
    rst_n = 1'b0;
    #1;
    check_quiet("rst_async");
    @(negedge clk);
    check_quiet("rst_hold");
    rst_n = 1'b1;
    settle(3);
    check_quiet("post_rst_idle");
    check_drained("post_rst_drained");

    // Six-register instance: out-of-range dst/src are rejected, in-range MV retires.
    run_b_check(16'hC000, 1'b1, 6'b000000, 16'd0);
    run_b_check(16'h1800, 1'b1, 6'b000000, 16'd0);
    run_b_check(16'h3900, 1'b1, 6'b000000, 16'd0);
    run_b_check(16'hA000, 1'b0, 6'b100000, 16'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
